bomb_stun_manager: RTL and testbench

//  Consumer end of each player's bomb request: takes bombRequested plus position from two

---
 rtl/bomb_stun_manager_pkg.sv | 20 ++
 rtl/bomb_stun_manager_slot.sv | 91 +++++++++
 rtl/bomb_stun_manager.sv | 131 +++++++++++++
 tb/tb_bomb_stun_manager.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/bomb_stun_manager_pkg.sv
// Shared definitions for the bomb/stun manager: slot state encoding, default
// coordinate width and a counter-sizing helper.
package bomb_stun_manager_pkg;

    localparam int DEFAULT_COORD_W = 6;

    typedef enum logic [1:0] {
        SLOT_IDLE  = 2'd0,
        SLOT_ARMED = 2'd1,
        SLOT_BLAST = 2'd2
    } slotState_t;

    // Bits needed to hold the value maxCount itself (never less than one bit).
    function automatic int counterWidth(input int maxCount);
        if (maxCount < 2)
            return 1;
        return $clog2(maxCount + 1);
    endfunction

endpackage

// File: rtl/bomb_stun_manager_slot.sv
// One bomb slot: accepts a qualified request edge, latches the tile, then runs
// the fuse and blast phases on a shared counter before returning to idle.
module bomb_slot
    import bomb_stun_manager_pkg::*;
#(
    parameter int COORD_W      = DEFAULT_COORD_W,
    parameter int FUSE_CYCLES  = 50_000_000,
    parameter int BLAST_CYCLES = 12_500_000
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               requestEdge,
    input  logic               blocked,
    input  logic [COORD_W-1:0] posX,
    input  logic [COORD_W-1:0] posY,
    output logic               accepted,
    output logic               armed,
    output logic               blasting,
    output logic [COORD_W-1:0] bombX,
    output logic [COORD_W-1:0] bombY
);

    localparam int CNT_W = counterWidth((FUSE_CYCLES > BLAST_CYCLES) ? FUSE_CYCLES : BLAST_CYCLES);
    localparam logic [CNT_W-1:0] FUSE_LAST  = CNT_W'(FUSE_CYCLES - 1);
    localparam logic [CNT_W-1:0] BLAST_LAST = CNT_W'(BLAST_CYCLES - 1);

    slotState_t       state;
    slotState_t       nextState;
    logic [CNT_W-1:0] phaseCnt;
    logic [CNT_W-1:0] nextPhaseCnt;
    logic             acceptNow;

    always_ff @(posedge clock) begin
        if (reset) begin
            state    <= SLOT_IDLE;
            phaseCnt <= '0;
            accepted <= 1'b0;
            bombX    <= '0;
            bombY    <= '0;
        end else begin
            state    <= nextState;
            phaseCnt <= nextPhaseCnt;
            accepted <= acceptNow;
            if (acceptNow) begin
                bombX <= posX;
                bombY <= posY;
            end
        end
    end

    // The phase counter restarts at every phase entry, so the last count value
    // of a phase is its length minus one.
    always_comb begin
        nextState    = state;
        nextPhaseCnt = phaseCnt;
        acceptNow    = 1'b0;
        unique case (state)
            SLOT_IDLE: begin
                if (requestEdge && !blocked) begin
                    acceptNow    = 1'b1;
                    nextState    = SLOT_ARMED;
                    nextPhaseCnt = '0;
                end
            end
            SLOT_ARMED: begin
                if (phaseCnt == FUSE_LAST) begin
                    nextState    = SLOT_BLAST;
                    nextPhaseCnt = '0;
                end else begin
                    nextPhaseCnt = phaseCnt + 1'b1;
                end
            end
            SLOT_BLAST: begin
                if (phaseCnt == BLAST_LAST) begin
                    nextState    = SLOT_IDLE;
                    nextPhaseCnt = '0;
                end else begin
                    nextPhaseCnt = phaseCnt + 1'b1;
                end
            end
            default: begin
                nextState    = SLOT_IDLE;
                nextPhaseCnt = '0;
            end
        endcase
    end

    assign armed    = (state == SLOT_ARMED);
    assign blasting = (state == SLOT_BLAST);

endmodule

// File: rtl/bomb_stun_manager.sv
// Bomb placement and stun control for two players: request edge detection,
// two bomb slots, cross-shaped blast hit test and per-player stun timers.
module bomb_stun_manager
    import bomb_stun_manager_pkg::*;
#(
    parameter int COORD_W      = DEFAULT_COORD_W,
    parameter int FUSE_CYCLES  = 50_000_000,
    parameter int BLAST_CYCLES = 12_500_000,
    parameter int STUN_CYCLES  = 100_000_000,
    parameter int BLAST_RADIUS = 2
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               bombRequestedP1,
    input  logic               bombRequestedP2,
    input  logic [COORD_W-1:0] p1X,
    input  logic [COORD_W-1:0] p1Y,
    input  logic [COORD_W-1:0] p2X,
    input  logic [COORD_W-1:0] p2Y,
    output logic [1:0]         bombAccepted,
    output logic [1:0]         bombArmed,
    output logic [1:0]         blastActive,
    output logic [COORD_W-1:0] bombX1,
    output logic [COORD_W-1:0] bombY1,
    output logic [COORD_W-1:0] bombX2,
    output logic [COORD_W-1:0] bombY2,
    output logic               stunnedEffectP1,
    output logic               stunnedEffectP2
);

    localparam int DIST_W = COORD_W + 1;
    localparam logic [DIST_W-1:0] RADIUS = DIST_W'(BLAST_RADIUS);
    localparam int STUN_W = counterWidth(STUN_CYCLES);
    localparam logic [STUN_W-1:0] STUN_LOAD = STUN_W'(STUN_CYCLES);

    logic [1:0]        prevRequest;
    logic [1:0]        requestEdge;
    logic [1:0]        hit;
    logic [STUN_W-1:0] stunCnt [2];
    logic [STUN_W-1:0] nextStunCnt [2];

    // Distances are taken one bit wider than the coordinates and never wrap,
    // so opposite edges of the map are far apart.
    function automatic logic crossHit(
        input logic [COORD_W-1:0] bx,
        input logic [COORD_W-1:0] by,
        input logic [COORD_W-1:0] px,
        input logic [COORD_W-1:0] py
    );
        logic [DIST_W-1:0] dx;
        logic [DIST_W-1:0] dy;
        dx = (bx >= px) ? ({1'b0, bx} - {1'b0, px}) : ({1'b0, px} - {1'b0, bx});
        dy = (by >= py) ? ({1'b0, by} - {1'b0, py}) : ({1'b0, py} - {1'b0, by});
        return ((dx == '0) && (dy <= RADIUS)) || ((dy == '0) && (dx <= RADIUS));
    endfunction

    always_ff @(posedge clock) begin
        if (reset)
            prevRequest <= 2'b00;
        else
            prevRequest <= {bombRequestedP2, bombRequestedP1};
    end

    assign requestEdge = {bombRequestedP2, bombRequestedP1} & ~prevRequest;

    bomb_slot #(
        .COORD_W      (COORD_W),
        .FUSE_CYCLES  (FUSE_CYCLES),
        .BLAST_CYCLES (BLAST_CYCLES)
    ) slotP1 (
        .clock       (clock),
        .reset       (reset),
        .requestEdge (requestEdge[0]),
        .blocked     (stunnedEffectP1),
        .posX        (p1X),
        .posY        (p1Y),
        .accepted    (bombAccepted[0]),
        .armed       (bombArmed[0]),
        .blasting    (blastActive[0]),
        .bombX       (bombX1),
        .bombY       (bombY1)
    );

    bomb_slot #(
        .COORD_W      (COORD_W),
        .FUSE_CYCLES  (FUSE_CYCLES),
        .BLAST_CYCLES (BLAST_CYCLES)
    ) slotP2 (
        .clock       (clock),
        .reset       (reset),
        .requestEdge (requestEdge[1]),
        .blocked     (stunnedEffectP2),
        .posX        (p2X),
        .posY        (p2Y),
        .accepted    (bombAccepted[1]),
        .armed       (bombArmed[1]),
        .blasting    (blastActive[1]),
        .bombX       (bombX2),
        .bombY       (bombY2)
    );

    // Either live blast can hit either player; overlapping hits merge into one reload.
    assign hit[0] = (blastActive[0] && crossHit(bombX1, bombY1, p1X, p1Y)) ||
                    (blastActive[1] && crossHit(bombX2, bombY2, p1X, p1Y));
    assign hit[1] = (blastActive[0] && crossHit(bombX1, bombY1, p2X, p2Y)) ||
                    (blastActive[1] && crossHit(bombX2, bombY2, p2X, p2Y));

    always_ff @(posedge clock) begin
        if (reset) begin
            stunCnt[0] <= '0;
            stunCnt[1] <= '0;
        end else begin
            stunCnt[0] <= nextStunCnt[0];
            stunCnt[1] <= nextStunCnt[1];
        end
    end

    always_comb begin
        for (int i = 0; i < 2; i++) begin
            nextStunCnt[i] = stunCnt[i];
            if (hit[i])
                nextStunCnt[i] = STUN_LOAD;
            else if (stunCnt[i] != '0)
                nextStunCnt[i] = stunCnt[i] - 1'b1;
        end
    end

    assign stunnedEffectP1 = (stunCnt[0] != '0);
    assign stunnedEffectP2 = (stunCnt[1] != '0);

endmodule

// File: tb/tb_bomb_stun_manager.sv
// Scoreboard bench for bomb_stun_manager: directed scenarios queue the expected
// rise/fall cycles of every output; a negedge monitor matches what the DUT does.
module tb_bomb_stun_manager;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       bombRequestedP1 = 1'b0;
    logic       bombRequestedP2 = 1'b0;
    logic [5:0] p1X = '0;
    logic [5:0] p1Y = '0;
    logic [5:0] p2X = '0;
    logic [5:0] p2Y = '0;
    logic [1:0] bombAccepted;
    logic [1:0] bombArmed;
    logic [1:0] blastActive;
    logic [5:0] bombX1;
    logic [5:0] bombY1;
    logic [5:0] bombX2;
    logic [5:0] bombY2;
    logic       stunnedEffectP1;
    logic       stunnedEffectP2;

    bomb_stun_manager #(
        .COORD_W      (6),
        .FUSE_CYCLES  (8),
        .BLAST_CYCLES (4),
        .STUN_CYCLES  (10),
        .BLAST_RADIUS (2)
    ) dut (
        .clock           (clock),
        .reset           (reset),
        .bombRequestedP1 (bombRequestedP1),
        .bombRequestedP2 (bombRequestedP2),
        .p1X             (p1X),
        .p1Y             (p1Y),
        .p2X             (p2X),
        .p2Y             (p2Y),
        .bombAccepted    (bombAccepted),
        .bombArmed       (bombArmed),
        .blastActive     (blastActive),
        .bombX1          (bombX1),
        .bombY1          (bombY1),
        .bombX2          (bombX2),
        .bombY2          (bombY2),
        .stunnedEffectP1 (stunnedEffectP1),
        .stunnedEffectP2 (stunnedEffectP2)
    );

    always #5 clock = ~clock;

    typedef struct {
        int ch;
        int rise;
        int fall;
        int x;
        int y;
    } expEvent_t;

    expEvent_t expQ[$];
    int        cyc = 0;
    int        checks = 0;
    int        errors = 0;
    logic [7:0] prevSig = '0;
    int        riseCyc [8];
    int        riseX [8];
    int        riseY [8];
    string     chName [8] = '{"accept0", "accept1", "armed0", "armed1",
                              "blast0", "blast1", "stunP1", "stunP2"};

    always @(posedge clock) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", name, actual, expected, cyc);
        end
    endtask

    task automatic pushExp(input int ch, input int rise, input int fall, input int x = 0, input int y = 0);
        expEvent_t e;
        e.ch = ch; e.rise = rise; e.fall = fall; e.x = x; e.y = y;
        expQ.push_back(e);
    endtask

    task automatic matchEvent(input int ch, input int rise, input int fall, input int x, input int y);
        int idx;
        idx = -1;
        for (int i = 0; i < expQ.size(); i++) begin
            if (expQ[i].ch == ch) begin
                idx = i;
                break;
            end
        end
        if (idx < 0) begin
            checkOutput({"unexpected_", chName[ch]}, rise, -1);
        end else begin
            checkOutput({chName[ch], "_rise"}, rise, expQ[idx].rise);
            checkOutput({chName[ch], "_fall"}, fall, expQ[idx].fall);
            if (ch < 2) begin
                checkOutput({chName[ch], "_bombX"}, x, expQ[idx].x);
                checkOutput({chName[ch], "_bombY"}, y, expQ[idx].y);
            end
            expQ.delete(idx);
        end
    endtask

    // Monitor: every level output is tracked; on its falling edge the oldest
    // expectation for that channel is popped and compared.
    always @(negedge clock) begin
        logic [7:0] sig;
        sig = {stunnedEffectP2, stunnedEffectP1, blastActive, bombArmed, bombAccepted};
        for (int ch = 0; ch < 8; ch++) begin
            if (sig[ch] && !prevSig[ch]) begin
                riseCyc[ch] = cyc;
                riseX[ch]   = (ch == 1) ? int'(bombX2) : int'(bombX1);
                riseY[ch]   = (ch == 1) ? int'(bombY2) : int'(bombY1);
            end else if (!sig[ch] && prevSig[ch]) begin
                matchEvent(ch, riseCyc[ch], cyc, riseX[ch], riseY[ch]);
            end
        end
        prevSig = sig;
    end

    task automatic nextCycle();
        @(posedge clock);
        #1;
    endtask

    task automatic waitUntil(input int c);
        while (cyc < c)
            nextCycle();
    endtask

    task automatic applyStimulus(input logic r1, input logic r2,
                                 input int x1, input int y1, input int x2, input int y2);
        bombRequestedP1 = r1;
        bombRequestedP2 = r2;
        p1X = 6'(x1);
        p1Y = 6'(y1);
        p2X = 6'(x2);
        p2Y = 6'(y2);
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, "_accepted"}, int'(bombAccepted), 0);
        checkOutput({tag, "_armed"}, int'(bombArmed), 0);
        checkOutput({tag, "_blast"}, int'(blastActive), 0);
        checkOutput({tag, "_bomb1"}, int'({bombX1, bombY1}), 0);
        checkOutput({tag, "_bomb2"}, int'({bombX2, bombY2}), 0);
        checkOutput({tag, "_stunned"}, int'({stunnedEffectP2, stunnedEffectP1}), 0);
    endtask

    initial begin
        int b, c, d, e, f;
        applyStimulus(0, 0, 10, 10, 13, 10);
        waitUntil(2);
        @(negedge clock);
        checkAllZero("reset");
        waitUntil(3);
        reset = 1'b0;

        // Own stun, near-miss tiles, stunned request drop, held request, radius edge on Y.
        b = 5;
        pushExp(0, b+1, b+2, 10, 10);  pushExp(2, b+1, b+9);  pushExp(4, b+9, b+13);
        pushExp(6, b+10, b+23);
        pushExp(7, b+13, b+23);
        pushExp(1, b+25, b+26, 30, 30); pushExp(3, b+25, b+33); pushExp(5, b+33, b+37);
        pushExp(0, b+31, b+32, 5, 0);  pushExp(2, b+31, b+39); pushExp(4, b+39, b+43);
        pushExp(6, b+40, b+53);
        waitUntil(b);    applyStimulus(1, 0, 10, 10, 13, 10);
        waitUntil(b+10); applyStimulus(1, 0, 10, 10, 11, 11);
        waitUntil(b+11); applyStimulus(1, 0, 10, 10, 13, 10);
        waitUntil(b+12); applyStimulus(1, 0, 10, 10, 12, 10);
        waitUntil(b+13); applyStimulus(1, 0, 10, 10, 30, 30);
        waitUntil(b+15); applyStimulus(1, 1, 10, 10, 30, 30);
        waitUntil(b+17); applyStimulus(1, 0, 10, 10, 30, 30);
        waitUntil(b+24); applyStimulus(1, 1, 10, 10, 30, 30);
        waitUntil(b+25); applyStimulus(1, 0, 10, 10, 30, 33);
        waitUntil(b+28); applyStimulus(0, 0, 10, 10, 30, 33);
        waitUntil(b+29); applyStimulus(0, 0, 5, 0, 30, 33);
        waitUntil(b+30); applyStimulus(1, 0, 5, 0, 30, 33);
        waitUntil(b+31); applyStimulus(0, 0, 5, 2, 30, 33);

        // Overlapping blasts on one tile with P1 standing on it: one merged stun.
        c = b + 60;
        pushExp(0, c+1, c+2, 20, 20); pushExp(2, c+1, c+9);  pushExp(4, c+9, c+13);
        pushExp(1, c+3, c+4, 20, 20); pushExp(3, c+3, c+11); pushExp(5, c+11, c+15);
        pushExp(6, c+10, c+25);
        waitUntil(c);   applyStimulus(1, 0, 20, 20, 20, 20);
        waitUntil(c+1); applyStimulus(0, 0, 20, 20, 20, 20);
        waitUntil(c+2); applyStimulus(0, 1, 20, 20, 20, 20);
        waitUntil(c+3); applyStimulus(0, 0, 20, 20, 40, 40);

        // Simultaneous requests; both players then stand just outside the radius.
        d = c + 30;
        pushExp(0, d+1, d+2, 4, 4);   pushExp(2, d+1, d+9); pushExp(4, d+9, d+13);
        pushExp(1, d+1, d+2, 50, 50); pushExp(3, d+1, d+9); pushExp(5, d+9, d+13);
        waitUntil(d);   applyStimulus(1, 1, 4, 4, 50, 50);
        waitUntil(d+1); applyStimulus(0, 0, 4, 7, 53, 50);

        // Bomb at column 0 must not reach columns 63/62; column 2 is hit.
        e = d + 20;
        pushExp(0, e+1, e+2, 0, 5); pushExp(2, e+1, e+9); pushExp(4, e+9, e+13);
        pushExp(7, e+13, e+23);
        waitUntil(e);    applyStimulus(1, 0, 0, 5, 63, 5);
        waitUntil(e+1);  applyStimulus(0, 0, 0, 20, 63, 5);
        waitUntil(e+10); applyStimulus(0, 0, 0, 20, 62, 5);
        waitUntil(e+12); applyStimulus(0, 0, 0, 20, 2, 5);
        waitUntil(e+13); applyStimulus(0, 0, 0, 20, 40, 40);

        // Reset in the fifth ARMED cycle aborts the bomb; no blast may follow.
        f = e + 30;
        pushExp(0, f+1, f+2, 7, 7); pushExp(2, f+1, f+6);
        waitUntil(f);   applyStimulus(1, 0, 7, 7, 40, 40);
        waitUntil(f+1); applyStimulus(0, 0, 7, 7, 40, 40);
        waitUntil(f+5); reset = 1'b1;
        waitUntil(f+6); reset = 1'b0;
        @(negedge clock);
        checkAllZero("midReset");

        waitUntil(f+30);
        @(negedge clock);
        checkOutput("pendingExpectations", expQ.size(), 0);
        checkOutput("openOutputs", int'(prevSig), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
